// File: rtl/odd_seq_checker.sv
// odd_seq_checker: receive-side checker for the odd-counter stream
// (1, 3, 5, ..., 2^W-1, 1, ...). Acquires the +2 progression, declares lock,
// then flags every sample that breaks it. All outputs are registered, so the
// response to a sample appears the cycle after in_valid.
module odd_seq_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic               parity_err_q, parity_err_d;

  logic [RUN_W-1:0]   run_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic               is_odd;
  logic               is_match;

  // Successor in the odd sequence; the natural wrap 2^W-1 -> 1 is intended.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
    return v + WIDTH'(2);
  endfunction

  assign run_inc  = run_q + RUN_W'(1);
  assign miss_inc = miss_q + MISS_W'(1);
  assign is_odd   = in_data[0];
  assign is_match = (in_data == expected_q);

  // Next-state logic: acquisition, lock tracking and error accounting.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    run_d        = run_q;
    miss_d       = miss_q;
    expected_d   = expected_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    parity_err_d = 1'b0;

    if (in_valid) begin
      // An even sample can never belong to the stream, whatever the state.
      parity_err_d = ~is_odd;

      unique case (state_q)
        S_IDLE: begin
          if (is_odd) begin
            expected_d = nxt(in_data);
            run_d      = RUN_W'(1);
            state_d    = S_ACQ;
          end
        end

        S_ACQ: begin
          if (is_match) begin
            run_d      = run_inc;
            expected_d = nxt(in_data);
            if (run_inc == RUN_W'(LOCK_CNT)) begin
              state_d = S_LOCKED;
              miss_d  = '0;
            end
          end else if (is_odd) begin
            // Re-seed on the new odd value instead of dropping back to IDLE.
            run_d      = RUN_W'(1);
            expected_d = nxt(in_data);
          end else begin
            run_d   = '0;
            state_d = S_IDLE;
          end
        end

        S_LOCKED: begin
          if (is_match) begin
            miss_d     = '0;
            expected_d = nxt(in_data);
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            // Flywheel: advance on our own prediction so one glitch does not
            // desynchronise the checker from a healthy stream.
            expected_d = nxt(expected_q);
            if (miss_inc == MISS_W'(UNLOCK_ERRS)) begin
              state_d = S_IDLE;
              miss_d  = '0;
              run_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          run_d   = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  assign locked_d = (state_d == S_LOCKED);

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      run_q        <= '0;
      miss_q       <= '0;
      expected_q   <= '0;
      err_count_q  <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      expected_q   <= expected_d;
      err_count_q  <= err_count_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign parity_err = parity_err_q;
  assign err_count  = err_count_q;
  assign expected   = expected_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Testbench for odd_seq_checker: directed steps, a reference model pushes the
// expected outputs into a scoreboard queue as each sample is driven, and the
// entry is popped and compared once the registered response is visible.
module tb_odd_seq_checker;

  localparam int WIDTH       = 8;
  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_ERRS = 3;
  localparam int CNT_W       = 4;  // narrow so saturation is reachable quickly

  typedef struct packed {
    logic             locked;
    logic             err_pulse;
    logic             parity_err;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] expected;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             locked;
  logic             err_pulse;
  logic             parity_err;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];

  // Reference model state (0 = idle, 1 = acquiring, 2 = locked).
  int               m_state;
  int               m_run;
  int               m_miss;
  logic [WIDTH-1:0] m_exp;
  logic [CNT_W-1:0] m_cnt;

  odd_seq_checker #(
    .WIDTH      (WIDTH),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .locked    (locked),
    .err_pulse (err_pulse),
    .parity_err(parity_err),
    .err_count (err_count),
    .expected  (expected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exv);
    n_vec++;
    assert (obs === exv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_run   = 0;
    m_miss  = 0;
    m_exp   = '0;
    m_cnt   = '0;
  endtask

  // Advance the model by one cycle and return the outputs it predicts.
  task automatic model_step(input bit v, input logic [WIDTH-1:0] d, output exp_t e);
    e = '0;
    if (v) begin
      e.parity_err = ~d[0];
      case (m_state)
        0: if (d[0]) begin
          m_exp   = WIDTH'(d + 2);
          m_run   = 1;
          m_state = 1;
        end
        1: if (d == m_exp) begin
          m_run = m_run + 1;
          m_exp = WIDTH'(d + 2);
          if (m_run == LOCK_CNT) begin
            m_state = 2;
            m_miss  = 0;
          end
        end else if (d[0]) begin
          m_run = 1;
          m_exp = WIDTH'(d + 2);
        end else begin
          m_run   = 0;
          m_state = 0;
        end
        default: if (d == m_exp) begin
          m_miss = 0;
          m_exp  = WIDTH'(d + 2);
        end else begin
          e.err_pulse = 1'b1;
          if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
          m_miss = m_miss + 1;
          m_exp  = WIDTH'(m_exp + 2);
          if (m_miss == UNLOCK_ERRS) begin
            m_state = 0;
            m_miss  = 0;
            m_run   = 0;
          end
        end
      endcase
    end
    e.locked    = (m_state == 2);
    e.expected  = m_exp;
    e.err_count = m_cnt;
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input bit v, input logic [WIDTH-1:0] d);
    exp_t e;
    exp_t got;
    model_step(v, d, e);
    sb.push_back(e);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("sb_locked",     32'(locked),     32'(got.locked));
    check("sb_err_pulse",  32'(err_pulse),  32'(got.err_pulse));
    check("sb_parity_err", 32'(parity_err), 32'(got.parity_err));
    check("sb_err_count",  32'(err_count),  32'(got.err_count));
    check("sb_expected",   32'(expected),   32'(got.expected));
    in_valid = 1'b0;
  endtask

  // Reset with a valid odd sample present to show reset wins.
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd1;
    repeat (cycles) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_err_pulse",  32'(err_pulse),  32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_err_count",  32'(err_count),  32'd0);
    check("rst_expected",   32'(expected),   32'd0);
  endtask

  task automatic lock_from(input logic [WIDTH-1:0] start);
    logic [WIDTH-1:0] v;
    v = start;
    for (int i = 0; i < LOCK_CNT; i++) begin
      step(1'b1, v);
      v = WIDTH'(v + 2);
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();

    // 1: basic acquisition, lock appears after the 4th good sample.
    do_reset(2);
    step(1'b1, 8'd1);
    step(1'b1, 8'd3);
    step(1'b1, 8'd5);
    check("t1_not_locked_yet", 32'(locked), 32'd0);
    step(1'b1, 8'd7);
    check("t1_locked",    32'(locked),    32'd1);
    check("t1_err_count", 32'(err_count), 32'd0);
    check("t1_expected",  32'(expected),  32'd9);

    // 2: wrap 255 -> 1 while locked is not an error.
    do_reset(1);
    lock_from(8'd243);
    step(1'b1, 8'd251);
    step(1'b1, 8'd253);
    step(1'b1, 8'd255);
    step(1'b1, 8'd1);
    check("t2_wrap_no_err", 32'(err_pulse), 32'd0);
    step(1'b1, 8'd3);
    check("t2_locked",   32'(locked),   32'd1);
    check("t2_expected", 32'(expected), 32'd5);

    // 3: single even glitch while locked.
    do_reset(1);
    lock_from(8'd5);
    check("t3_exp13", 32'(expected), 32'd13);
    step(1'b1, 8'd13);
    step(1'b1, 8'd40);
    check("t3_err_pulse",  32'(err_pulse),  32'd1);
    check("t3_parity_err", 32'(parity_err), 32'd1);
    step(1'b1, 8'd17);
    check("t3_err_count", 32'(err_count), 32'd1);
    check("t3_lock_kept", 32'(locked),    32'd1);

    // 4: three consecutive misses unlock.
    do_reset(1);
    lock_from(8'd1);
    step(1'b1, 8'd99);
    step(1'b1, 8'd99);
    check("t4_still_locked", 32'(locked), 32'd1);
    step(1'b1, 8'd99);
    check("t4_err_pulse",  32'(err_pulse), 32'd1);
    check("t4_unlocked",   32'(locked),    32'd0);
    check("t4_err_count",  32'(err_count), 32'd3);
    step(1'b1, 8'd15);
    check("t4_count_kept", 32'(err_count), 32'd3);

    // 5: even sample in IDLE, then acquisition starts on 5.
    do_reset(1);
    step(1'b1, 8'd4);
    check("t5_parity_err", 32'(parity_err), 32'd1);
    check("t5_idle_exp",   32'(expected),   32'd0);
    step(1'b1, 8'd5);
    step(1'b1, 8'd7);
    check("t5_expected", 32'(expected), 32'd9);
    check("t5_unlocked", 32'(locked),   32'd0);

    // 6: reset in the middle of a locked stream.
    do_reset(1);
    lock_from(8'd1);
    step(1'b1, 8'd99);
    step(1'b1, 8'd11);
    step(1'b1, 8'd99);
    check("t6_err_count", 32'(err_count), 32'd2);
    do_reset(1);
    step(1'b1, 8'd17);
    check("t6_idle_restart", 32'(locked), 32'd0);

    // 7: gaps in in_valid hold state and keep pulses low.
    do_reset(1);
    step(1'b1, 8'd1);
    step(1'b0, 8'd2);
    step(1'b1, 8'd3);
    step(1'b0, 8'd0);
    step(1'b0, 8'd77);
    step(1'b1, 8'd5);
    step(1'b0, 8'd6);
    step(1'b1, 8'd7);
    step(1'b0, 8'd8);
    check("t7_locked",   32'(locked),     32'd1);
    check("t7_expected", 32'(expected),   32'd9);
    check("t7_no_pulse", 32'(parity_err), 32'd0);

    // Saturation of err_count, alternating miss/good to stay locked.
    do_reset(1);
    lock_from(8'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'd100);
      step(1'b1, expected);
    end
    check("sat_count",  32'(err_count), 32'((1 << CNT_W) - 1));
    check("sat_locked", 32'(locked),    32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
